// File: rtl/drumbit_audio_pkg.sv
// Shared definitions for the drumbit audio path.
//   feeder_state_e : playback state of pwm_sample_feeder (IDLE, FILL, PLAY)
//   UNITY_GAIN     : gain code that leaves a sample unchanged
//   UNDERRUN_CNT_W : width of the saturating underrun counter
package drumbit_audio_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      PLAY = 2'd2
   } feeder_state_e;

   localparam int UNITY_GAIN     = 8;
   localparam int UNDERRUN_CNT_W = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead head output and synchronous reset.
// Ports:
//   clk, rst     : clock and synchronous active-high reset
//   push, din    : write request and data; ignored while full
//   pop          : read request; ignored while empty
//   head         : entry at the read pointer (valid when !empty)
//   full, empty  : occupancy flags
//   level        : occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);
   assign level = count;
   assign head  = mem[rd_ptr];

   // Storage is not reset; only the pointers and count define validity.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/pwm_sample_feeder.sv
// Feeds scaled audio samples to the pwm block, one duty value per PWM period.
// Ports:
//   clk, rst        : clock and synchronous active-high reset
//   enable          : playback enable (shared with pwm.enable)
//   s_valid/s_ready : upstream handshake, s_sample is the unsigned sample
//   gain            : volume, duty = (sample*gain)>>3, saturated
//   pwm_counter     : counter of the downstream pwm instance
//   duty_cycle      : registered duty value for pwm.duty_cycle
//   level           : FIFO occupancy
//   underrun        : one-cycle pulse when a period ends with no sample
//   underrun_count  : saturating count of underruns
//   state           : current playback state, for observation
//
// Handshake: a sample transfers on any rising edge where s_valid && s_ready.
// s_ready depends only on the FIFO being non-full, never on s_valid, so the
// upstream may hold s_valid and s_sample stable until the transfer happens.
module pwm_sample_feeder
   import drumbit_audio_pkg::*;
#(
   parameter int CTRVAL = 256,
   parameter int CTRLEN = $clog2(CTRVAL),
   parameter int DEPTH  = 4,
   parameter int GAIN_W = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         enable,
   input  logic                         s_valid,
   output logic                         s_ready,
   input  logic [CTRLEN-1:0]            s_sample,
   input  logic [GAIN_W-1:0]            gain,
   input  logic [CTRLEN-1:0]            pwm_counter,
   output logic [CTRLEN-1:0]            duty_cycle,
   output logic [$clog2(DEPTH):0]       level,
   output logic                         underrun,
   output logic [UNDERRUN_CNT_W-1:0]    underrun_count,
   output feeder_state_e                state
);

   localparam int LW         = $clog2(DEPTH) + 1;
   localparam int PW         = CTRLEN + GAIN_W;
   localparam int GAIN_SHIFT = $clog2(UNITY_GAIN);

   feeder_state_e     state_next;
   logic [CTRLEN-1:0] head;
   logic [CTRLEN-1:0] scaled;
   logic [CTRLEN-1:0] duty_next;
   logic [PW-1:0]     prod;
   logic [PW-1:0]     shifted;
   logic              fifo_full;
   logic              fifo_empty;
   logic              push;
   logic              pop;
   logic              period_end;
   logic              underrun_evt;

   assign s_ready    = !fifo_full;
   assign push       = s_valid && s_ready;
   assign period_end = enable && (pwm_counter == CTRLEN'(CTRVAL - 1));

   sync_fifo #(
      .WIDTH (CTRLEN),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (s_sample),
      .pop   (pop),
      .head  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (level)
   );

   // Gain stage works on the FIFO head so the value is ready before the pop.
   assign prod    = PW'(head) * PW'(gain);
   assign shifted = prod >> GAIN_SHIFT;
   assign scaled  = (shifted > PW'(CTRVAL - 1)) ? CTRLEN'(CTRVAL - 1)
                                                : shifted[CTRLEN-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next   = state;
      duty_next    = duty_cycle;
      pop          = 1'b0;
      underrun_evt = 1'b0;
      if (!enable) begin
         state_next = IDLE;
         duty_next  = '0;
      end else begin
         case (state)
            IDLE: begin
               duty_next  = '0;
               state_next = FILL;
            end
            FILL: begin
               // level here is the occupancy after the previous edge's push.
               duty_next = '0;
               if (level >= LW'(DEPTH / 2)) begin
                  state_next = PLAY;
               end
            end
            PLAY: begin
               if (period_end) begin
                  if (!fifo_empty) begin
                     pop       = 1'b1;
                     duty_next = scaled;
                  end else begin
                     // Hold the last duty; a push this cycle is stored, not bypassed.
                     underrun_evt = 1'b1;
                  end
               end
            end
            default: begin
               state_next = IDLE;
               duty_next  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         duty_cycle     <= '0;
         underrun       <= 1'b0;
         underrun_count <= '0;
      end else begin
         duty_cycle <= duty_next;
         underrun   <= underrun_evt;
         if (underrun_evt && (underrun_count != '1)) begin
            underrun_count <= underrun_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pwm_sample_feeder.sv
// Self-checking bench for pwm_sample_feeder: directed steps from the test
// plan followed by a randomized phase, all checked against a queue-based
// reference model after every clock edge.
module tb_pwm_sample_feeder;
   import drumbit_audio_pkg::*;

   localparam int CTRVAL = 256;
   localparam int DEPTH  = 4;

   logic          clk;
   logic          rst;
   logic          enable;
   logic          s_valid;
   logic          s_ready;
   logic [7:0]    s_sample;
   logic [3:0]    gain;
   logic [7:0]    pwm_counter;
   logic [7:0]    duty_cycle;
   logic [2:0]    level;
   logic          underrun;
   logic [7:0]    underrun_count;
   feeder_state_e state;

   int errors = 0;
   int checks = 0;

   // Reference model: buffered samples, mode, and the expected outputs.
   logic [7:0]    exp_q[$];
   feeder_state_e m_state;
   int            m_duty;
   int            m_under;
   int            m_ucount;

   pwm_sample_feeder #(
      .CTRVAL (CTRVAL),
      .DEPTH  (DEPTH),
      .GAIN_W (4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .enable         (enable),
      .s_valid        (s_valid),
      .s_ready        (s_ready),
      .s_sample       (s_sample),
      .gain           (gain),
      .pwm_counter    (pwm_counter),
      .duty_cycle     (duty_cycle),
      .level          (level),
      .underrun       (underrun),
      .underrun_count (underrun_count),
      .state          (state)
   );

   // Clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advances the model by one clock edge using the inputs currently driven.
   task automatic model_step();
      bit ready;
      bit pe;
      int p;
      if (rst) begin
         exp_q.delete();
         m_state  = IDLE;
         m_duty   = 0;
         m_under  = 0;
         m_ucount = 0;
         return;
      end
      ready   = (exp_q.size() < DEPTH);
      pe      = enable && (pwm_counter == 8'(CTRVAL - 1));
      m_under = 0;
      if (!enable) begin
         m_state = IDLE;
         m_duty  = 0;
      end else if (m_state == IDLE) begin
         m_state = FILL;
         m_duty  = 0;
      end else if (m_state == FILL) begin
         m_duty = 0;
         if (exp_q.size() >= DEPTH / 2) m_state = PLAY;
      end else if (pe) begin
         if (exp_q.size() > 0) begin
            p = (int'(exp_q.pop_front()) * int'(gain)) / 8;
            m_duty = (p > CTRVAL - 1) ? CTRVAL - 1 : p;
         end else begin
            m_under = 1;
            if (m_ucount < 255) m_ucount++;
         end
      end
      if (s_valid && ready) exp_q.push_back(s_sample);
   endtask

   task automatic check_all();
      check("duty_cycle", 32'(duty_cycle), 32'(m_duty));
      check("level", 32'(level), 32'(exp_q.size()));
      check("s_ready", 32'(s_ready), 32'(exp_q.size() < DEPTH));
      check("underrun", 32'(underrun), 32'(m_under));
      check("underrun_count", 32'(underrun_count), 32'(m_ucount));
      check("state", 32'(state), 32'(m_state));
   endtask

   // Driver: apply one cycle of inputs, update the model, check after the edge.
   task automatic step(input logic r, input logic en, input logic sv,
                       input logic [7:0] smp, input logic [3:0] g,
                       input logic [7:0] ctr);
      rst         = r;
      enable      = en;
      s_valid     = sv;
      s_sample    = smp;
      gain        = g;
      pwm_counter = ctr;
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; s_valid = 1'b0;
      s_sample = '0; gain = 4'd8; pwm_counter = '0;

      // 1. Reset held two cycles with s_valid high: nothing accepted.
      step(1, 0, 1, 8'h11, 8, 0);
      step(1, 0, 1, 8'h22, 8, 0);
      check("rst_level", 32'(level), 0);
      check("rst_ready", 32'(s_ready), 1);
      check("rst_duty", 32'(duty_cycle), 0);
      step(0, 0, 0, 8'h00, 8, 0);

      // 2. Priming and play.
      step(0, 1, 1, 8'h40, 8, 0);
      step(0, 1, 1, 8'h80, 8, 0);
      step(0, 1, 0, 8'h00, 8, 0);
      check("prime_state", 32'(state), 32'(PLAY));
      step(0, 1, 0, 8'h00, 8, 8'hFF);
      check("play_duty0", 32'(duty_cycle), 32'h40);
      check("play_level", 32'(level), 1);
      step(0, 1, 0, 8'h00, 8, 8'h00);
      step(0, 1, 0, 8'h00, 8, 8'hFF);
      check("play_duty1", 32'(duty_cycle), 32'h80);

      // 3. Gain: saturation, half gain, zero gain.
      step(0, 1, 1, 8'hC0, 8, 0);
      step(0, 1, 1, 8'h80, 8, 0);
      step(0, 1, 1, 8'h10, 8, 0);
      step(0, 1, 0, 8'h00, 15, 8'hFF);
      check("gain_sat", 32'(duty_cycle), 32'hFF);
      step(0, 1, 0, 8'h00, 4, 8'h00);
      step(0, 1, 0, 8'h00, 4, 8'hFF);
      check("gain_half", 32'(duty_cycle), 32'h40);
      step(0, 1, 0, 8'h00, 0, 8'hFF);
      check("gain_zero", 32'(duty_cycle), 32'h00);

      // 4. Backpressure: fill, hold a 5th sample, free a slot, accept it.
      step(0, 1, 1, 8'h10, 8, 0);
      step(0, 1, 1, 8'h20, 8, 0);
      step(0, 1, 1, 8'h30, 8, 0);
      step(0, 1, 1, 8'h40, 8, 0);
      check("bp_full_ready", 32'(s_ready), 0);
      step(0, 1, 1, 8'h80, 8, 0);
      check("bp_level", 32'(level), 4);
      step(0, 1, 1, 8'h80, 8, 8'hFF);
      check("bp_ready_again", 32'(s_ready), 1);
      step(0, 1, 1, 8'h80, 8, 0);
      check("bp_accepted", 32'(level), 4);

      // 5. Underrun: drain to 0x80, then an empty period end, then saturate.
      for (int i = 0; i < 4; i++) step(0, 1, 0, 8'h00, 8, 8'hFF);
      check("ur_last_duty", 32'(duty_cycle), 32'h80);
      step(0, 1, 0, 8'h00, 8, 8'hFF);
      check("ur_pulse", 32'(underrun), 1);
      check("ur_hold_duty", 32'(duty_cycle), 32'h80);
      check("ur_count1", 32'(underrun_count), 1);
      step(0, 1, 0, 8'h00, 8, 8'h00);
      check("ur_pulse_end", 32'(underrun), 0);
      for (int i = 0; i < 300; i++) step(0, 1, 0, 8'h00, 8, 8'hFF);
      check("ur_saturate", 32'(underrun_count), 255);

      // 6. Mid-operation enable drop, re-enable, then reset.
      step(0, 1, 1, 8'h01, 8, 0);
      step(0, 1, 1, 8'h02, 8, 0);
      step(0, 1, 1, 8'h03, 8, 0);
      step(0, 0, 0, 8'h00, 8, 0);
      check("drop_state", 32'(state), 32'(IDLE));
      check("drop_level", 32'(level), 3);
      check("drop_duty", 32'(duty_cycle), 0);
      step(0, 1, 0, 8'h00, 8, 0);
      step(0, 1, 0, 8'h00, 8, 0);
      check("reenable_play", 32'(state), 32'(PLAY));
      step(1, 1, 1, 8'h55, 8, 8'hFF);
      check("midrst_level", 32'(level), 0);
      check("midrst_state", 32'(state), 32'(IDLE));

      // 7. Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 99) == 0),
              1'($urandom_range(0, 19) != 0),
              1'($urandom_range(0, 1)),
              8'($urandom_range(0, 255)),
              4'($urandom_range(0, 15)),
              ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
